// File: rtl/y_mat_fetch_ctrl.sv
// y_mat_fetch_ctrl
// Fetches one packed row-index word from the index SRAM, then walks its rows in the
// order 1,2..ROWS-1,0. Each row issues two Y SRAM reads: the row's address field,
// then that address plus one. Each returned Y datum is forwarded downstream with
// row/half/last tags aligned to the SRAM's one-cycle read latency.
// The row counter and output row tag are 4 bits wide, so ROWS may be at most 16.
module y_mat_fetch_ctrl #(
    parameter int ROWS    = 16,
    parameter int FIELD_W = 10,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 yFC_start,
    input  logic [ADDR_W-1:0]    yFC_idx_addr,
    output logic                 yFC_busy,
    output logic                 yFC_done,
    output logic                 yFC_idxRd_en,
    output logic [ADDR_W-1:0]    yFC_idxRd_addr,
    input  logic [16*ROWS-1:0]   yFC_idxRd_data,
    output logic                 yFC_yRd_en,
    output logic [ADDR_W-1:0]    yFC_yRd_addr,
    input  logic [DATA_W-1:0]    yFC_yRd_data,
    input  logic                 yFC_out_ready,
    output logic                 yFC_out_valid,
    output logic [DATA_W-1:0]    yFC_out_data,
    output logic [3:0]           yFC_out_row,
    output logic                 yFC_out_half,
    output logic                 yFC_out_last
);

    // Bit-position width needed to address any 16-bit slot in the packed word.
    localparam int POS_W = $clog2(16 * ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDX_RD,
        S_IDX_WAIT,
        S_ROW_A,
        S_ROW_B,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [16*ROWS-1:0]    word_q;
    logic [3:0]            row_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  idx_en_q;
    logic [ADDR_W-1:0]     idx_addr_q;

    // Tag pipe: one stage, lines up with Y SRAM read data.
    logic                  vld_q;
    logic [3:0]            tag_row_q;
    logic                  half_q;
    logic                  last_q;

    logic                  issue_d;
    logic                  half_d;
    logic                  last_d;
    logic [3:0]            slot_d;
    logic [POS_W-1:0]      bitpos_d;
    logic [FIELD_W-1:0]    field_d;
    logic [ADDR_W-1:0]     base_d;
    logic [ADDR_W-1:0]     yaddr_d;

    // Issue decision and Y address: row r lives in slot (ROWS-r) mod ROWS, so row 0
    // is the lowest slot and row 1 the highest. The slot's upper bits are dropped.
    always_comb begin
        issue_d  = yFC_out_ready && ((state_q == S_ROW_A) || (state_q == S_ROW_B));
        half_d   = (state_q == S_ROW_B);
        last_d   = half_d && (row_q == 4'd0);
        slot_d   = (row_q == 4'd0) ? 4'd0 : (4'(ROWS) - row_q);
        bitpos_d = POS_W'({slot_d, 4'b0000});
        field_d  = word_q[bitpos_d +: FIELD_W];
        base_d   = ADDR_W'(field_d);
        // The field is narrower than ADDR_W, so addr+1 cannot wrap.
        yaddr_d  = half_d ? (base_d + ADDR_W'(1)) : base_d;
    end

    // Run sequencer with registered busy/done/index-read outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            row_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_en_q   <= 1'b0;
            idx_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (yFC_start) begin
                        state_q    <= S_IDX_RD;
                        busy_q     <= 1'b1;
                        idx_en_q   <= 1'b1;
                        idx_addr_q <= yFC_idx_addr;
                    end
                end
                S_IDX_RD: begin
                    state_q    <= S_IDX_WAIT;
                    idx_en_q   <= 1'b0;
                    idx_addr_q <= '0;
                end
                S_IDX_WAIT: begin
                    word_q  <= yFC_idxRd_data;
                    row_q   <= 4'd1;
                    state_q <= S_ROW_A;
                end
                S_ROW_A: begin
                    if (yFC_out_ready) begin
                        state_q <= S_ROW_B;
                    end
                end
                S_ROW_B: begin
                    if (yFC_out_ready) begin
                        if (row_q == 4'd0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            row_q   <= (row_q == 4'(ROWS - 1)) ? 4'd0 : (row_q + 4'd1);
                            state_q <= S_ROW_A;
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    idx_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Delay the issue-time tags by one cycle so they travel with the returned datum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q     <= 1'b0;
            tag_row_q <= 4'd0;
            half_q    <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            vld_q     <= issue_d;
            tag_row_q <= issue_d ? row_q : 4'd0;
            half_q    <= issue_d && half_d;
            last_q    <= issue_d && last_d;
        end
    end

    // Output drive: strobes are zero outside issue cycles, data is gated by valid.
    always_comb begin
        yFC_busy       = busy_q;
        yFC_done       = done_q;
        yFC_idxRd_en   = idx_en_q;
        yFC_idxRd_addr = idx_addr_q;
        yFC_yRd_en     = issue_d;
        yFC_yRd_addr   = issue_d ? yaddr_d : '0;
        yFC_out_valid  = vld_q;
        yFC_out_data   = vld_q ? yFC_yRd_data : '0;
        yFC_out_row    = tag_row_q;
        yFC_out_half   = half_q;
        yFC_out_last   = last_q;
    end

endmodule
